mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/accel_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter_rr_arbiter.sv | 28 ++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared accelerator constants and shared-memory arbiter state encoding
package accel_pkg;

    localparam int NUM_PROCESSING_UNITS = 4;
    localparam int LEN_W                = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request, grant and shared-memory signals between processing units and the arbiter
interface mem_arbiter_if #(
    parameter int NUM_REQ = accel_pkg::NUM_PROCESSING_UNITS,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*4-1:0]      req_len;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        wr_ack;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;
    logic [15:0]               perf_wait;

    modport slave (
        input  req, req_we, req_addr, req_len, req_wdata, mem_rdata,
        output gnt, wr_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, busy, perf_wait
    );

    modport master (
        output req, req_we, req_addr, req_len, req_wdata, mem_rdata,
        input  gnt, wr_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, busy, perf_wait
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// rtl/mem_arbiter_rr_arbiter.sv - combinational round-robin pick: first set request above rr_ptr, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic               valid_o,
    output logic [PTR_W-1:0]   winner_o
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        cand     = '0;
        // The last-served unit is visited last, giving it lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr_i) + i) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o  = 1'b1;
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin burst arbiter onto one shared memory port; MEM_ARB_PERF_EN adds a wait counter
module mem_arbiter
    import accel_pkg::*;
#(
    parameter int NUM_REQ = NUM_PROCESSING_UNITS,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;

    logic              pick_valid;
    logic [PTR_W-1:0]  pick;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] owner_wdata;

    logic [NUM_REQ-1:0] gnt, wr_ack, rd_valid;
    logic [DATA_W-1:0]  rd_data, mem_wdata;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_en, mem_we;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid),
        .winner_o (pick)
    );

    assign beat_addr   = base_q + ADDR_W'(beat_q);
    assign owner_wdata = bus.req_wdata[owner_q*DATA_W +: DATA_W];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        we_d         = we_q;
        base_d       = base_q;
        len_d        = len_q;
        beat_d       = beat_q;
        rd_pend_d    = 1'b0;
        addr_hold_d  = addr_hold_q;
        wdata_hold_d = wdata_hold_q;
        gnt          = '0;
        wr_ack       = '0;
        rd_valid     = '0;
        rd_data      = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = addr_hold_q;
        mem_wdata    = wdata_hold_q;

        // Read data returns one cycle after its beat, still tagged to the latched owner.
        if (rd_pend_q) begin
            rd_valid[owner_q] = 1'b1;
            rd_data           = bus.mem_rdata;
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_BURST;
                    rr_ptr_d = pick;
                    owner_d  = pick;
                    we_d     = bus.req_we[pick];
                    base_d   = bus.req_addr[pick*ADDR_W +: ADDR_W];
                    len_d    = bus.req_len[pick*LEN_W +: LEN_W];
                    beat_d   = '0;
                end
            end
            ARB_BURST: begin
                mem_en        = 1'b1;
                mem_we        = we_q;
                mem_addr      = beat_addr;
                addr_hold_d   = beat_addr;
                gnt[owner_q]  = (beat_q == '0);
                if (we_q) begin
                    mem_wdata       = owner_wdata;
                    wdata_hold_d    = owner_wdata;
                    wr_ack[owner_q] = 1'b1;
                end else begin
                    rd_pend_d = 1'b1;
                end
                if (beat_q == len_q) begin
                    state_d = we_q ? ARB_IDLE : ARB_DRAIN;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ARB_DRAIN: state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= PTR_W'(NUM_REQ - 1);
            owner_q      <= '0;
            we_q         <= 1'b0;
            base_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            rd_pend_q    <= 1'b0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            base_q       <= base_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            rd_pend_q    <= rd_pend_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.wr_ack    = wr_ack;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_data;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.busy      = (state_q != ARB_IDLE);

`ifdef MEM_ARB_PERF_EN
    logic [15:0]        perf_q, perf_d;
    logic [NUM_REQ-1:0] served_mask;

    // The unit being picked in IDLE or owning the burst is not counted as waiting.
    always_comb begin
        served_mask = '0;
        served_mask[(state_q == ARB_IDLE) ? pick : owner_q] = 1'b1;
        perf_d = perf_q;
        if (((bus.req & ~served_mask) != '0) && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.perf_wait = perf_q;
`else
    assign bus.perf_wait = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter plus reset and wait-counter sequences
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(32)) bus ();

    mem_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory returns a tagged copy of the read address one cycle later.
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= {16'hA5A5, bus.mem_addr};
    end

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [3:0]  len;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  wr_ack;
        logic [3:0]  rd_valid;
        logic [31:0] rd_data;
        logic        mem_en;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] W_A = 32'h1111_000A;
    localparam logic [31:0] W_B = 32'h2222_000B;
    localparam logic [31:0] W_C = 32'h3333_000C;
    localparam logic [31:0] W_D = 32'h4444_000D;
    localparam logic [31:0] W_X = 32'hC0DE_0000;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] w,
                                input logic [15:0] a, input logic [3:0] l, input logic [31:0] wd,
                                input logic [3:0] g, input logic [3:0] wa, input logic [3:0] rv,
                                input logic [31:0] rd, input logic en, input logic mwe,
                                input logic [15:0] ma, input logic [31:0] mwd, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.we = w; v.addr = a; v.len = l; v.wdata = wd;
        v.gnt = g; v.wr_ack = wa; v.rd_valid = rv; v.rd_data = rd;
        v.mem_en = en; v.mem_we = mwe; v.mem_addr = ma; v.mem_wdata = mwd; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] rq, input logic [3:0] w, input logic [15:0] a,
                          input logic [3:0] l, input logic [31:0] wd);
        bus.req       = rq;
        bus.req_we    = w;
        bus.req_addr  = {4{a}};
        bus.req_len   = {4{l}};
        bus.req_wdata = {4{wd}};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  seen;
        int  exp_perf;

        set_in(4'b0, 4'b0, 16'h0, 4'h0, 32'h0);
        rst = 1'b1;
        repeat (3) step();
        chk("reset gnt",      64'(bus.gnt),       64'h0);
        chk("reset mem_en",   64'(bus.mem_en),    64'h0);
        chk("reset busy",     64'(bus.busy),      64'h0);
        chk("reset rd_valid", 64'(bus.rd_valid),  64'h0);
        chk("reset wr_ack",   64'(bus.wr_ack),    64'h0);
        chk("reset mem_addr", 64'(bus.mem_addr),  64'h0);
        chk("reset perf",     64'(bus.perf_wait), 64'h0);
        rst = 1'b0;

        // Read burst, unit 0, 0x0010, 4 beats; last return in DRAIN.
        vecs.push_back(mk(0, 4'h1, 4'h0, 16'h0010, 3, 0, 4'h0, 4'h0, 4'h0, 0,            0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 4'h1, 4'h0, 16'h0010, 3, 0, 4'h1, 4'h0, 4'h0, 0,            1, 0, 16'h0010, 0, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'h0010, 3, 0, 4'h0, 4'h0, 4'h1, 32'hA5A50010, 1, 0, 16'h0011, 0, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'h0010, 3, 0, 4'h0, 4'h0, 4'h1, 32'hA5A50011, 1, 0, 16'h0012, 0, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'h0010, 3, 0, 4'h0, 4'h0, 4'h1, 32'hA5A50012, 1, 0, 16'h0013, 0, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'h0010, 3, 0, 4'h0, 4'h0, 4'h1, 32'hA5A50013, 0, 0, 16'h0013, 0, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'h0010, 3, 0, 4'h0, 4'h0, 4'h0, 0,            0, 0, 16'h0013, 0, 0));
        // Write burst, unit 2, wrapping past 0xFFFF.
        vecs.push_back(mk(0, 4'h4, 4'h4, 16'hFFFE, 3, W_A, 4'h0, 4'h0, 4'h0, 0, 0, 0, 16'h0013, 0,   0));
        vecs.push_back(mk(0, 4'h4, 4'h4, 16'hFFFE, 3, W_A, 4'h4, 4'h4, 4'h0, 0, 1, 1, 16'hFFFE, W_A, 1));
        vecs.push_back(mk(0, 4'h0, 4'h4, 16'hFFFE, 3, W_B, 4'h0, 4'h4, 4'h0, 0, 1, 1, 16'hFFFF, W_B, 1));
        vecs.push_back(mk(0, 4'h0, 4'h4, 16'hFFFE, 3, W_C, 4'h0, 4'h4, 4'h0, 0, 1, 1, 16'h0000, W_C, 1));
        vecs.push_back(mk(0, 4'h0, 4'h4, 16'hFFFE, 3, W_D, 4'h0, 4'h4, 4'h0, 0, 1, 1, 16'h0001, W_D, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'hFFFE, 3, 0,   4'h0, 4'h0, 4'h0, 0, 0, 0, 16'h0001, 0,   0));
        // Reset, then all four request single-beat writes together.
        vecs.push_back(mk(1, 4'h0, 4'h0, 16'h0000, 0, 0,   4'h0, 4'h0, 4'h0, 0, 0, 0, 16'h0001, 0,   0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'h0200, 0, W_X, 4'h0, 4'h0, 4'h0, 0, 0, 0, 16'h0000, 0,   0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'h0200, 0, W_X, 4'h1, 4'h1, 4'h0, 0, 1, 1, 16'h0200, W_X, 1));
        vecs.push_back(mk(0, 4'hE, 4'hF, 16'h0200, 0, W_X, 4'h0, 4'h0, 4'h0, 0, 0, 0, 16'h0200, 0,   0));
        vecs.push_back(mk(0, 4'hE, 4'hF, 16'h0200, 0, W_X, 4'h2, 4'h2, 4'h0, 0, 1, 1, 16'h0200, W_X, 1));
        vecs.push_back(mk(0, 4'hC, 4'hF, 16'h0200, 0, W_X, 4'h0, 4'h0, 4'h0, 0, 0, 0, 16'h0200, 0,   0));
        vecs.push_back(mk(0, 4'hC, 4'hF, 16'h0200, 0, W_X, 4'h4, 4'h4, 4'h0, 0, 1, 1, 16'h0200, W_X, 1));
        vecs.push_back(mk(0, 4'h8, 4'hF, 16'h0200, 0, W_X, 4'h0, 4'h0, 4'h0, 0, 0, 0, 16'h0200, 0,   0));
        vecs.push_back(mk(0, 4'h8, 4'hF, 16'h0200, 0, W_X, 4'h8, 4'h8, 4'h0, 0, 1, 1, 16'h0200, W_X, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'h0200, 0, 0,   4'h0, 4'h0, 4'h0, 0, 0, 0, 16'h0200, 0,   0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            set_in(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("row%0d gnt", i),      64'(bus.gnt),      64'(vecs[i].gnt));
            chk($sformatf("row%0d wr_ack", i),   64'(bus.wr_ack),   64'(vecs[i].wr_ack));
            chk($sformatf("row%0d rd_valid", i), 64'(bus.rd_valid), 64'(vecs[i].rd_valid));
            chk($sformatf("row%0d mem_en", i),   64'(bus.mem_en),   64'(vecs[i].mem_en));
            chk($sformatf("row%0d mem_we", i),   64'(bus.mem_we),   64'(vecs[i].mem_we));
            chk($sformatf("row%0d mem_addr", i), 64'(bus.mem_addr), 64'(vecs[i].mem_addr));
            chk($sformatf("row%0d busy", i),     64'(bus.busy),     64'(vecs[i].busy));
            if (vecs[i].rd_valid != 4'h0)
                chk($sformatf("row%0d rd_data", i), 64'(bus.rd_data), 64'(vecs[i].rd_data));
            if (vecs[i].mem_we)
                chk($sformatf("row%0d mem_wdata", i), 64'(bus.mem_wdata), 64'(vecs[i].mem_wdata));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        // Reset during the second beat of an 8-beat read.
        set_in(4'b0001, 4'b0000, 16'h0100, 4'd7, 32'h0);
        step();
        chk("abort gnt0", 64'(bus.gnt), 64'h1);
        set_in(4'b0000, 4'b0000, 16'h0100, 4'd7, 32'h0);
        step();
        chk("abort beat1 addr",  64'(bus.mem_addr), 64'h0101);
        chk("abort beat1 rdval", 64'(bus.rd_valid), 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort mem_en",   64'(bus.mem_en),   64'h0);
        chk("abort rd_valid", 64'(bus.rd_valid), 64'h0);
        chk("abort busy",     64'(bus.busy),     64'h0);
        set_in(4'b0010, 4'b0000, 16'h0100, 4'd7, 32'h0);
        step();
        chk("abort regrant", 64'(bus.gnt), 64'h2);
        set_in(4'b0000, 4'b0000, 16'h0100, 4'd7, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (!bus.busy) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("abort burst done", 64'(seen), 64'h1);

        // Units 0 and 1 collide on 2-beat reads; unit 1 waits four cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_in(4'b0011, 4'b0000, 16'h0040, 4'd1, 32'h0);
        cyc  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.gnt[0]) begin
                chk("perf gnt0 cycle", 64'(k), 64'd1);
                bus.req[0] = 1'b0;
            end
            if (bus.gnt[1]) begin
                cyc  = k;
                seen = 1'b1;
                bus.req[1] = 1'b0;
                break;
            end
        end
        chk("perf gnt1 seen",  64'(seen), 64'h1);
        chk("perf gnt1 cycle", 64'(cyc),  64'd5);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.busy) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("perf burst done", 64'(seen), 64'h1);
`ifdef MEM_ARB_PERF_EN
        exp_perf = 4;
`else
        exp_perf = 0;
`endif
        chk("perf_wait", 64'(bus.perf_wait), 64'(exp_perf));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
